pl_skid_stage: RTL and testbench

PL_SKID_STAGE -- requirements
Module: pl_skid_stage

---
 rtl/pl_skid_stage_if.sv | 31 +++
 rtl/pl_skid_stage.sv | 110 +++++++++++
 tb/tb_pl_skid_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pl_skid_stage_if.sv
// Purpose : bundles the upstream/downstream handshake, flush and status signals of pl_skid_stage.
// Latency : n/a (wires only).
// Backpressure: n/a; master drives stage inputs, slave is the stage itself.
interface pl_skid_stage_if #(
    parameter int DW = 32,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;

    // Stage side.
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready, flush,
        output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
    );

    // Upstream/downstream side driving the stage.
    modport master (
        output in_valid, in_data, in_ctrl, out_ready, flush,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
    );
endinterface

// File: rtl/pl_skid_stage.sv
// Purpose : two-entry (main + skid) pipeline register stage with flush; optional stall counter via PL_STALL_CNT_EN.
// Latency : 1 cycle from accept to out_valid; sustains one transfer per cycle.
// Backpressure: in_ready is a pure register decode (!skid valid), so out_ready never reaches in_ready combinationally.
module pl_skid_stage #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    pl_skid_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_data_q, skid_data_q;
    logic [CW-1:0] main_ctrl_q, skid_ctrl_q;

    logic main_vld, skid_vld;
    logic acc, cons;
    logic main_load_in, main_load_skid, skid_load;

    // State register; valids are decoded from it so reset clears them immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next-state: flush dominates, otherwise accept/consume move between EMPTY/ONE/FULL.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (acc) state_d = ONE;
                ONE:     if (acc && !cons) state_d = FULL;
                         else if (!acc && cons) state_d = EMPTY;
                FULL:    if (cons) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs and datapath load enables decoded from the current state.
    always_comb begin
        main_vld       = (state_q == ONE) || (state_q == FULL);
        skid_vld       = (state_q == FULL);
        acc            = bus.in_valid && !skid_vld;
        cons           = main_vld && bus.out_ready;
        main_load_in   = !bus.flush && acc && ((state_q == EMPTY) || ((state_q == ONE) && cons));
        main_load_skid = !bus.flush && (state_q == FULL) && cons;
        skid_load      = !bus.flush && acc && (state_q == ONE) && !cons;
        bus.in_ready   = !skid_vld;
        bus.out_valid  = main_vld;
        bus.out_data   = main_data_q;
        bus.out_ctrl   = main_vld ? main_ctrl_q : '0;
        bus.occupancy  = {1'b0, main_vld} + {1'b0, skid_vld};
    end

    // Payload registers only load on accept or skid->main move; stale contents are don't-care.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (main_load_in) begin
                main_data_q <= bus.in_data;
                main_ctrl_q <= bus.in_ctrl;
            end else if (main_load_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (skid_load) begin
                skid_data_q <= bus.in_data;
                skid_ctrl_q <= bus.in_ctrl;
            end
        end
    end

`ifdef PL_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where the head is valid but downstream refuses it.
    always_comb begin
        stall_d = stall_q;
        if (bus.flush)
            stall_d = '0;
        else if (main_vld && !bus.out_ready && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pl_skid_stage.sv
module tb_pl_skid_stage;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fails;

`ifdef PL_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    pl_skid_stage_if #(.DW(32), .CW(8)) bus ();

    pl_skid_stage #(.DW(32), .CW(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        nRST          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_ctrl",  {24'd0, bus.out_ctrl},  32'd0);
        check("rst_out_data",  bus.out_data,            32'd0);
        check("rst_occ",       {30'd0, bus.occupancy}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_stall",     bus.stall_cnt,           32'd0);

        // Release reset between edges; first accept on the very next edge
        #5;
        nRST          = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1234;
        bus.in_ctrl   = 8'h05;
        bus.out_ready = 1'b1;
        step();
        check("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first_data",  bus.out_data,            32'h1234);
        check("first_ctrl",  {24'd0, bus.out_ctrl},  32'h05);
        check("first_occ",   {30'd0, bus.occupancy}, 32'd1);

        // Back-to-back stream with downstream always ready
        for (int i = 0; i < 4; i++) begin
            check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            bus.in_data = 32'h10 + i;
            bus.in_ctrl = 8'h20 + 8'(i);
            step();
            check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stream_data",  bus.out_data,            32'h10 + i);
            check("stream_ctrl",  {24'd0, bus.out_ctrl},  32'h20 + i);
        end
        bus.in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drain_ctrl",  {24'd0, bus.out_ctrl},  32'd0);
        check("drain_occ",   {30'd0, bus.occupancy}, 32'd0);

        // Fill to FULL under backpressure, then hold
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA;
        bus.in_ctrl   = 8'h01;
        step();
        check("bp_occ1",      {30'd0, bus.occupancy}, 32'd1);
        check("bp_in_ready1", {31'd0, bus.in_ready},  32'd1);
        bus.in_data = 32'hB;
        bus.in_ctrl = 8'h02;
        step();
        bus.in_valid = 1'b0;
        check("bp_occ2",      {30'd0, bus.occupancy}, 32'd2);
        check("bp_in_ready2", {31'd0, bus.in_ready},  32'd0);
        check("bp_head",      bus.out_data,            32'hA);
        for (int i = 0; i < 4; i++) step();
        check("stall_cnt",    bus.stall_cnt,           EXP_STALL);
        check("hold_occ",     {30'd0, bus.occupancy}, 32'd2);
        check("hold_head",    bus.out_data,            32'hA);

        // Release: A then B in order, in_ready back after first consume
        bus.out_ready = 1'b1;
        step();
        check("rel_data1",     bus.out_data,            32'hB);
        check("rel_ctrl1",     {24'd0, bus.out_ctrl},  32'h02);
        check("rel_occ1",      {30'd0, bus.occupancy}, 32'd1);
        check("rel_in_ready1", {31'd0, bus.in_ready},  32'd1);
        step();
        check("rel_occ0",      {30'd0, bus.occupancy}, 32'd0);
        check("rel_valid0",    {31'd0, bus.out_valid}, 32'd0);

        // FULL, then flush with a concurrent incoming 0xC
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hD;
        bus.in_ctrl   = 8'h03;
        step();
        bus.in_data = 32'hE;
        step();
        check("pre_flush_occ", {30'd0, bus.occupancy}, 32'd2);
        bus.in_data = 32'hC;
        bus.in_ctrl = 8'h0C;
        bus.flush   = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("flush_ctrl",     {24'd0, bus.out_ctrl},  32'd0);
        check("flush_occ",      {30'd0, bus.occupancy}, 32'd0);
        check("flush_in_ready", {31'd0, bus.in_ready},  32'd1);
        check("flush_stall",    bus.stall_cnt,           32'd0);
        bus.out_ready = 1'b1;
        step();
        check("flush_no_C",     {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h21;
        bus.in_ctrl   = 8'h11;
        step();
        bus.in_data = 32'h22;
        step();
        bus.in_valid = 1'b0;
        check("arst_pre_occ", {30'd0, bus.occupancy}, 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("arst_ctrl",     {24'd0, bus.out_ctrl},  32'd0);
        check("arst_data",     bus.out_data,            32'd0);
        check("arst_occ",      {30'd0, bus.occupancy}, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready},  32'd1);
        check("arst_stall",    bus.stall_cnt,           32'd0);
        nRST = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
